// File: rtl/seq_mul_pkg.sv
// Shared constants and helpers for the sequential shift-and-add multiplier.
package seq_mul_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int unsigned calcNSteps(input int unsigned bW, input int unsigned step);
    return bW / step;
  endfunction

  function automatic int unsigned calcCntW(input int unsigned nSteps);
    return $clog2(nSteps + 1);
  endfunction

endpackage

// File: rtl/mul_pp_add.sv
// Forms aExt x chunk (top chunk MSB optionally negative-weighted) and adds it
// into the accumulator at the given bit weight.
module mul_pp_add #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned STEP  = 1,
  parameter int unsigned SH_W  = 6
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] aExt,
  input  logic [STEP-1:0]  chunk,
  input  logic             negTop,
  input  logic [SH_W-1:0]  shiftAmt,
  output logic [ACC_W-1:0] sum_c
);

  logic [ACC_W-1:0] pp;

  always_comb begin
    pp = '0;
    for (int i = 0; i < int'(STEP); i++) begin
      if (chunk[i]) begin
        // Signed top chunk: its MSB carries negative weight, so subtract.
        if (negTop && (i == int'(STEP) - 1)) pp = pp - (aExt << i);
        else                                 pp = pp + (aExt << i);
      end
    end
    sum_c = acc + (pp << shiftAmt);
  end

endmodule

// File: rtl/seq_mul_pipe.sv
// Sequential radix-2^STEP multiplier with valid/ready handshakes, signed or
// unsigned per transaction; one product every NSTEPS+2 cycles.
module seq_mul_pipe
  import seq_mul_pkg::*;
#(
  parameter int unsigned A_W  = 32,
  parameter int unsigned B_W  = 8,
  parameter int unsigned STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               is_signed,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] y
);

  localparam int unsigned NSTEPS = calcNSteps(B_W, STEP);
  localparam int unsigned CNT_W  = calcCntW(NSTEPS);
  localparam int unsigned ACC_W  = A_W + B_W;
  localparam int unsigned SH_W   = $clog2(ACC_W);

  if ((B_W % STEP) != 0) begin : gBadStep
    $error("seq_mul_pipe: STEP must divide B_W");
  end
  if (A_W < 2 || B_W < 2) begin : gBadWidth
    $error("seq_mul_pipe: A_W and B_W must be at least 2");
  end

  logic [1:0]       state, stateNext;
  logic [A_W-1:0]   aReg, aNext;
  logic [B_W-1:0]   bReg, bNext;
  logic             signedReg, signedNext;
  logic [ACC_W-1:0] acc, accNext, yNext, ppSum_c, aExt;
  logic [CNT_W-1:0] count, countNext;
  logic             inReadyNext, outValidNext;
  logic             lastStep, negTop;
  logic [SH_W-1:0]  shiftAmt;

  assign aExt     = {{B_W{signedReg & aReg[A_W-1]}}, aReg};
  assign lastStep = (count == CNT_W'(NSTEPS - 1));
  assign negTop   = signedReg & lastStep;
  assign shiftAmt = SH_W'(count) * SH_W'(STEP);

  // bReg shifts right each step, so its low STEP bits are always the live chunk.
  mul_pp_add #(
    .ACC_W (ACC_W),
    .STEP  (STEP),
    .SH_W  (SH_W)
  ) uPpAdd (
    .acc      (acc),
    .aExt     (aExt),
    .chunk    (bReg[STEP-1:0]),
    .negTop   (negTop),
    .shiftAmt (shiftAmt),
    .sum_c    (ppSum_c)
  );

  // Next-state and next-register logic; abort always takes priority.
  always_comb begin
    stateNext  = state;
    aNext      = aReg;
    bNext      = bReg;
    signedNext = signedReg;
    accNext    = acc;
    countNext  = count;
    yNext      = y;
    case (state)
      IDLE: begin
        if (!abort && in_valid) begin
          aNext      = a;
          bNext      = b;
          signedNext = is_signed;
          accNext    = '0;
          countNext  = '0;
          stateNext  = BUSY;
        end
      end
      BUSY: begin
        if (abort) begin
          stateNext = IDLE;
          yNext     = '0;
        end else begin
          accNext   = ppSum_c;
          countNext = count + CNT_W'(1);
          bNext     = bReg >> STEP;
          if (lastStep) begin
            stateNext = DONE;
            yNext     = ppSum_c;
          end
        end
      end
      DONE: begin
        if (abort) begin
          stateNext = IDLE;
          yNext     = '0;
        end else if (out_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    inReadyNext  = (stateNext == IDLE);
    outValidNext = (stateNext == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      aReg      <= '0;
      bReg      <= '0;
      signedReg <= 1'b0;
      acc       <= '0;
      count     <= '0;
      y         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= stateNext;
      aReg      <= aNext;
      bReg      <= bNext;
      signedReg <= signedNext;
      acc       <= accNext;
      count     <= countNext;
      y         <= yNext;
      in_ready  <= inReadyNext;
      out_valid <= outValidNext;
    end
  end

endmodule

// File: tb/tb_seq_mul_pipe.sv
// Bench for seq_mul_pipe: STEP=1/2/4 instances share stimulus and are checked
// against a plain-arithmetic product model.
module tb_seq_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [7:0]  b = '0;

  logic        inReady1, inReady2, inReady4;
  logic        outValid1, outValid2, outValid4;
  logic [39:0] y1, y2, y4;

  int nChecks = 0;
  int nFail = 0;
  int lat1, lat2, lat4;
  logic [39:0] exp;
  logic [39:0] yHold;
  logic        sawValid;

  always #5 clk = ~clk;

  seq_mul_pipe #(.A_W(32), .B_W(8), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady1), .a(a), .b(b),
    .is_signed(is_signed), .abort(abort), .out_valid(outValid1), .out_ready(out_ready), .y(y1));
  seq_mul_pipe #(.A_W(32), .B_W(8), .STEP(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady2), .a(a), .b(b),
    .is_signed(is_signed), .abort(abort), .out_valid(outValid2), .out_ready(out_ready), .y(y2));
  seq_mul_pipe #(.A_W(32), .B_W(8), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady4), .a(a), .b(b),
    .is_signed(is_signed), .abort(abort), .out_valid(outValid4), .out_ready(out_ready), .y(y4));

  function automatic logic [39:0] refMul(input logic [31:0] x, input logic [7:0] m, input logic s);
    logic [63:0] px, pm, prod;
    px = {{32{s & x[31]}}, x};
    pm = {{56{s & m[7]}}, m};
    prod = px * pm;
    return prod[39:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nChecks++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one transaction on all instances and wait (bounded) for every product.
  task automatic issue(input logic [31:0] x, input logic [7:0] m, input logic s);
    a = x; b = m; is_signed = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = 8'($urandom);
    lat1 = 99; lat2 = 99; lat4 = 99;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (outValid1 && lat1 == 99) lat1 = c;
      if (outValid2 && lat2 == 99) lat2 = c;
      if (outValid4 && lat4 == 99) lat4 = c;
      if (lat1 != 99 && lat2 != 99 && lat4 != 99) break;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic checkAll(input string tag, input logic [39:0] e);
    check({tag, " y1"}, 64'(y1), 64'(e));
    check({tag, " y2"}, 64'(y2), 64'(e));
    check({tag, " y4"}, 64'(y4), 64'(e));
    check({tag, " lat1"}, 64'(lat1), 64'd8);
    check({tag, " lat2"}, 64'(lat2), 64'd4);
    check({tag, " lat4"}, 64'(lat4), 64'd2);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 64'(inReady1), 64'd1);
    check("rst out_valid", 64'(outValid1), 64'd0);
    check("rst y", 64'(y1), 64'd0);
    rst = 1'b0;
    tick();

    // Directed corner products
    issue(32'hFFFF_FFFF, 8'hFF, 1'b0);
    checkAll("u max", 40'hFE_FFFF_FF01);
    consume();
    issue(32'h8000_0000, 8'h7F, 1'b1);
    checkAll("s minpos", 40'hC0_8000_0000);
    consume();
    issue(32'hFFFF_FFFF, 8'hFF, 1'b1);
    checkAll("s m1m1", 40'h00_0000_0001);
    consume();

    // Output backpressure: product held, no new accept
    issue(32'h0001_0003, 8'h05, 1'b0);
    checkAll("u small", 40'h00_0005_000F);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold y", 64'(y1), 64'h00_0005_000F);
      check("hold in_ready", 64'(inReady1), 64'd0);
      check("hold out_valid", 64'(outValid1), 64'd1);
    end
    in_valid = 1'b0;
    consume();
    check("post in_ready", 64'(inReady1), 64'd1);
    check("post out_valid", 64'(outValid1), 64'd0);
    check("post y kept", 64'(y1), 64'h00_0005_000F);

    // abort in IDLE beats in_valid
    abort = 1'b1; in_valid = 1'b1; a = 32'd7; b = 8'd9;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("idle abort in_ready", 64'(inReady1), 64'd1);
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); sawValid |= outValid1; end
    check("idle abort no valid", 64'(sawValid), 64'd0);

    // abort on third BUSY cycle
    a = 32'h1234_5678; b = 8'hA5; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort in_ready", 64'(inReady1), 64'd1);
    check("abort out_valid", 64'(outValid1), 64'd0);
    check("abort y", 64'(y1), 64'd0);
    check("abort y4 done", 64'(y4), 64'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); sawValid |= outValid1; end
    check("abort no valid", 64'(sawValid), 64'd0);
    issue(32'd3, 8'd5, 1'b0);
    checkAll("after abort", 40'd15);
    consume();

    // Asynchronous reset between edges mid-BUSY
    a = 32'hDEAD_BEEF; b = 8'h3C; is_signed = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("arst in_ready", 64'(inReady1), 64'd1);
    check("arst out_valid", 64'(outValid1), 64'd0);
    check("arst y", 64'(y1), 64'd0);
    #2 rst = 1'b0;
    tick();
    issue(32'hDEAD_BEEF, 8'h3C, 1'b1);
    checkAll("after arst", refMul(32'hDEAD_BEEF, 8'h3C, 1'b1));
    consume();

    // Random vectors in both modes
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] ra;
      logic [7:0]  rb;
      logic        rs;
      ra = $urandom;
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (n % 50 == 0) ra = {ra[31], 31'd0};
      issue(ra, rb, rs);
      exp = refMul(ra, rb, rs);
      check("rand y1", 64'(y1), 64'(exp));
      check("rand y2", 64'(y2), 64'(exp));
      check("rand y4", 64'(y4), 64'(exp));
      if (n % 100 == 0) begin
        check("rand lat2", 64'(lat2), 64'd4);
        check("rand lat4", 64'(lat4), 64'd2);
      end
      consume();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
